// File: rtl/flag_gen.sv
// Condition-flag generator: one-entry capture stage feeding a {Z,V,N} register.
// Define FLAG_FWD_EN to forward the pending merged flags to z/v/n and tie busy low.
module flag_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] result,
  output logic        z,
  output logic        v,
  output logic        n,
  output logic        busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD   = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b010;
  localparam logic [OP_W-1:0] OP_LOGIC = 3'b011;
  localparam logic [OP_W-1:0] OP_SHIFT = 3'b100;
  localparam logic [OP_W-1:0] OP_LOADF = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] result;
  } s1_t;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  state_t state_q, state_d;
  s1_t    s1_q, s1_d;
  flags_t flags_q, flags_d;
  flags_t merged_c;
  logic   zc_c, nc_c, vadd_c, vsub_c;

  // Architectural flags with the captured update merged in.
  always_comb begin
    zc_c     = (s1_q.result == '0);
    nc_c     = s1_q.result[DATA_W-1];
    vadd_c   = (s1_q.a[DATA_W-1] == s1_q.b[DATA_W-1]) && (nc_c != s1_q.a[DATA_W-1]);
    vsub_c   = (s1_q.a[DATA_W-1] != s1_q.b[DATA_W-1]) && (nc_c != s1_q.a[DATA_W-1]);
    merged_c = flags_q;
    case (s1_q.op)
      OP_ADD:             merged_c = '{z: zc_c, v: vadd_c, n: nc_c};
      OP_SUB:             merged_c = '{z: zc_c, v: vsub_c, n: nc_c};
      OP_LOGIC, OP_SHIFT: merged_c.z = zc_c;
      OP_LOADF:           merged_c = flags_t'(s1_q.a[2:0]);
      default:            merged_c = flags_q;
    endcase
  end

  // Capture/commit control; flush beats stall, stall freezes everything.
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    flags_d = flags_q;
    if (flush) begin
      state_d = IDLE;
    end else if (!stall) begin
      state_d = in_valid ? PEND : IDLE;
      s1_d    = '{op: op, a: a, b: b, result: result};
      if (state_q == PEND) begin
        flags_d = merged_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s1_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      flags_q <= flags_d;
    end
  end

`ifdef FLAG_FWD_EN
  always_comb begin
    {z, v, n} = (state_q == PEND) ? merged_c : flags_q;
    busy      = 1'b0;
  end
`else
  always_comb begin
    {z, v, n} = flags_q;
    busy      = (state_q == PEND);
  end
`endif

endmodule

// File: tb/tb_flag_gen.sv
// Self-checking bench for flag_gen: directed vector table, reset/forwarding corners,
// and randomized traffic against a queue-based reference model.
module tb_flag_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, flush;
  logic [2:0]  op;
  logic [15:0] a, b, result;
  logic        z, v, n, busy;

  int checks = 0;
  int errors = 0;

  flag_gen dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .a(a), .b(b), .result(result),
    .z(z), .v(v), .n(n), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: updates in flight plus the architectural {Z,V,N}.
  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
  } rec_t;

  rec_t       inflight[$];
  logic [2:0] mflags;

  function automatic logic [2:0] apply_flags(logic [2:0] f, rec_t r);
    int   sa, sb, full;
    logic zf, nf, vf;
    zf = (r.result == 16'd0);
    nf = ($signed(r.result) < 0);
    sa = int'($signed(r.a));
    sb = int'($signed(r.b));
    case (r.op)
      3'd1: begin full = sa + sb; vf = (full > 32767) || (full < -32768); return {zf, vf, nf}; end
      3'd2: begin full = sa - sb; vf = (full > 32767) || (full < -32768); return {zf, vf, nf}; end
      3'd3, 3'd4: return {zf, f[1:0]};
      3'd5: return r.a[2:0];
      default: return f;
    endcase
  endfunction

  function automatic logic [3:0] exp_out();
`ifdef FLAG_FWD_EN
    if (inflight.size() != 0) return {apply_flags(mflags, inflight[0]), 1'b0};
    return {mflags, 1'b0};
`else
    return {mflags, inflight.size() != 0};
`endif
  endfunction

  task automatic model_edge();
    rec_t r;
    if (flush) begin
      inflight.delete();
    end else if (!stall) begin
      if (inflight.size() != 0) begin
        r = inflight.pop_front();
        mflags = apply_flags(mflags, r);
      end
      if (in_valid) begin
        r.op = op; r.a = a; r.b = b; r.result = result;
        inflight.push_back(r);
      end
    end
  endtask

  task automatic step(input logic iv, input logic st, input logic fl, input logic [2:0] o,
                      input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] rr);
    in_valid = iv; stall = st; flush = fl; op = o; a = aa; b = bb; result = rr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    checks++;
    if ({z, v, n, busy} !== exp) begin
      errors++;
      $display("FAIL %s got zvn_busy=%b want %b", name, {z, v, n, busy}, exp);
    end
  endtask

  typedef struct {
    logic        iv, st, fl;
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic [3:0]  exp;  // {z,v,n,busy} after the edge, non-forwarding build
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic iv, logic st, logic fl, logic [2:0] o, logic [15:0] aa,
                              logic [15:0] bb, logic [15:0] rr, logic [3:0] e);
    vec_t t;
    t.iv = iv; t.st = st; t.fl = fl; t.op = o; t.a = aa; t.b = bb; t.res = rr; t.exp = e;
    return t;
  endfunction

  initial begin
    logic [2:0]  ro;
    logic [15:0] ra, rb, rr;

    tbl[0]  = mk(1, 0, 0, 3'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0001);
    tbl[1]  = mk(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b0110);
    tbl[2]  = mk(1, 0, 0, 3'd2, 16'h0005, 16'h0005, 16'h0000, 4'b0111);
    tbl[3]  = mk(1, 0, 0, 3'd3, 16'h00FF, 16'h00F0, 16'h00F0, 4'b1001);
    tbl[4]  = mk(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
    tbl[5]  = mk(1, 0, 0, 3'd5, 16'h0007, 16'h0000, 16'h0000, 4'b0001);
    tbl[6]  = mk(1, 0, 0, 3'd4, 16'h8000, 16'h0010, 16'h0000, 4'b1111);
    tbl[7]  = mk(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b1110);
    tbl[8]  = mk(1, 0, 0, 3'd1, 16'h0001, 16'h0001, 16'h0002, 4'b1111);
    tbl[9]  = mk(1, 1, 0, 3'd2, 16'h0003, 16'h0003, 16'h0000, 4'b1111);
    tbl[10] = mk(1, 1, 0, 3'd2, 16'h0003, 16'h0003, 16'h0000, 4'b1111);
    tbl[11] = mk(0, 1, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b1111);
    tbl[12] = mk(1, 1, 1, 3'd1, 16'h0001, 16'h0001, 16'h0002, 4'b1110);
    tbl[13] = mk(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b1110);
    tbl[14] = mk(1, 0, 1, 3'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'b1110);
    tbl[15] = mk(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b1110);
    tbl[16] = mk(1, 0, 0, 3'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'b1111);
    tbl[17] = mk(1, 0, 0, 3'd0, 16'h1234, 16'h0000, 16'h0000, 4'b0101);
    tbl[18] = mk(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b0100);
    tbl[19] = mk(1, 0, 0, 3'd7, 16'h0000, 16'h0000, 16'h0000, 4'b0101);
    tbl[20] = mk(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b0100);

    rst_n = 1'b0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; result = '0;
    inflight.delete();
    mflags = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
    check("post_reset", 4'b0000);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].iv, tbl[i].st, tbl[i].fl, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res);
`ifdef FLAG_FWD_EN
      check($sformatf("vec%0d", i), exp_out());
`else
      check($sformatf("vec%0d", i), tbl[i].exp);
`endif
    end

    // Asynchronous reset while an update is captured but not yet committed.
    step(1, 0, 0, 3'd1, 16'h7FFF, 16'h0001, 16'h8000);
    check("rst_pre", exp_out());
    #2;
    rst_n = 1'b0;
    inflight.delete();
    mflags = 3'b000;
    #1;
    check("rst_async", 4'b0000);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 3'd1, 16'h7FFF, 16'h0001, 16'h8000);
      check($sformatf("rst_nocommit%0d", i), 4'b0000);
    end

`ifdef FLAG_FWD_EN
    step(1, 0, 0, 3'd1, 16'h0000, 16'h0000, 16'h0000);
    check("fwd_z_early", 4'b1000);
    step(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    check("fwd_z_commit", 4'b1000);
`endif

    for (int i = 0; i < 3000; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      case (ro)
        3'd1: rr = 16'(ra + rb);
        3'd2: rr = 16'(ra - rb);
        3'd3: rr = ra ^ rb;
        3'd4: rr = 16'(ra << rb[3:0]);
        default: rr = 16'($urandom);
      endcase
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 9) == 0), ro, ra, rb, rr);
      check($sformatf("rand%0d", i), exp_out());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_gen.md
FLAG_GEN -- requirements
Module: flag_gen

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-003 SHALL have port: in_valid  input  1  ALU result presented this cycle.
REQ-004 SHALL have port: stall  input  1  hold all state (pipeline stall).
REQ-005 SHALL have port: flush  input  1  discard the pending (uncommitted) update.
REQ-006 SHALL have port: op  input  3  flag class: 000 NONE, 001 ADD, 010 SUB, 011 LOGIC, 100 SHIFT, 101 LOADF; 110/111 treated as NONE.
REQ-007 SHALL have port: a  input  16  ALU operand A (LOADF: a[2:0] = {z,v,n}).
REQ-008 SHALL have port: b  input  16  ALU operand B.
REQ-009 SHALL have port: result  input  16  ALU result (SUB: result = a - b).
REQ-010 SHALL have ports: z, v, n  output  1 each  flag values presented to the condition-evaluation unit.
REQ-011 SHALL have port: busy  output  1  flag update in flight; consumer holds condition evaluation.

Function
REQ-012 SHALL hold a one-entry capture stage (s1: valid, op, a, b, result) and a 3-bit architectural flag register {Z,V,N}.
REQ-013 SHALL load s1 with {in_valid, op, a, b, result} on each edge where stall=0 and flush=0.
REQ-014 SHALL clear s1.valid on any edge where flush=1; flush overrides stall and in_valid.
REQ-015 SHALL hold s1 and the flag register unchanged on edges where stall=1 and flush=0.
REQ-016 SHALL commit computed flags on an edge iff s1.valid=1, stall=0, flush=0 (latency: input cycle +2 edges to architectural register).
REQ-017 SHALL compute next flags from s1: Zc = (result==16'h0); Nc = result[15].
REQ-018 SHALL compute Vc for ADD = (a[15]==b[15]) && (result[15]!=a[15]).
REQ-019 SHALL compute Vc for SUB = (a[15]!=b[15]) && (result[15]!=a[15]).
REQ-020 ADD/SUB SHALL write Z, V, N; LOGIC/SHIFT SHALL write Z only, retaining V, N; LOADF SHALL write {Z,V,N}=a[2:0]; NONE SHALL write nothing.
REQ-021 SHALL treat s1.valid as a two-state machine: IDLE (0) and PEND (1); IDLE->PEND on capture of in_valid=1; PEND->IDLE on commit with no new capture; PEND->PEND on back-to-back capture or stall.
REQ-022 Back-to-back valid inputs SHALL each commit in order, one per unstalled cycle, with no lost update.
REQ-023 A flush on the same edge as in_valid=1 SHALL drop both the pending and incoming updates.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear s1.valid, s1 payload, and {Z,V,N} to 0.
REQ-025 During and immediately after reset SHALL drive z=0, v=0, n=0, busy=0.
REQ-026 Reset asserted mid-update SHALL discard the pending update; no commit after release until a new in_valid.

Configuration
REQ-027 Macro FLAG_FWD_EN SHALL select the flag-forwarding path.
REQ-028 With FLAG_FWD_EN defined: z/v/n SHALL present the merged next flags (REQ-020 applied to the architectural register) whenever s1.valid=1, else the register; busy SHALL be constant 0.
REQ-029 Without FLAG_FWD_EN: z/v/n SHALL present the architectural register only; busy SHALL equal s1.valid.

Verification
REQ-030 ADD a=16'h7FFF, b=16'h0001, result=16'h8000 -> after 2 edges Z=0, V=1, N=1; busy high exactly 1 cycle (no FWD).
REQ-031 SUB a=16'h0005, b=16'h0005, result=16'h0000, then LOGIC result=16'h00F0 -> Z=1,V=0,N=0 then Z=0,V=0,N=0 on consecutive cycles.
REQ-032 Flags {1,1,1} via LOADF a=3'b111, then SHIFT result=16'h0000 -> Z=1, V=1, N=1 retained.
REQ-033 ADD pending, stall=1 for 3 cycles, then flush=1 -> flags unchanged, busy falls after flush edge.
REQ-034 rst_n pulsed low mid-cycle with s1.valid=1 -> z/v/n/busy=0 immediately, no commit after release.
REQ-035 FLAG_FWD_EN build, ADD result=16'h0000 -> z=1 visible in the cycle after the input edge, busy=0 throughout.
